rx_buffer_vliw: RTL
===================

# rx_buffer_vliw

Receive-side byte buffer between the UART receiver and the VLIW core. It queues bytes delivered by the receiver and presents the head byte to the `in` instruction path. It drives the `Rx_ready` level that the hazard unit uses to hold an `in` instruction in Decode, and it pops one byte each time the core retires an `in` read. Overflow is detected, the byte is dropped, and a sticky flag is set for software and debug visibility.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: buffer depth is 2^DEPTH_LOG2 entries (16).
- `WIDTH`, default 8: data width in bits.

Ports:
- `clk`, input, 1: core clock.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `rx_data`, input, WIDTH: byte from the UART receiver.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `in_ack`, input, 1: core consumed the head byte (the `in` instruction advances out of Decode unstalled); one pop per asserted cycle.
- `overrun_clr`, input, 1: clears the sticky `overrun` flag.
- `Rx_ready`, output, 1: buffer non-empty; head byte valid.
- `in_data`, output, WIDTH: head byte; 0 when empty.
- `count`, output, DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `overrun`, output, 1: sticky; a byte was dropped because the buffer was full.

## Operation

- Storage is a circular register array with `wr_ptr` and `rd_ptr` (DEPTH_LOG2 bits each, natural wrap) and an occupancy counter `count`.
- Push: `rx_valid` writes `rx_data` to `mem[wr_ptr]`, then `wr_ptr` increments. A push is accepted when `count` < DEPTH, or when `count` == DEPTH and a pop occurs in the same cycle.
- Push refused (full, no simultaneous pop): the byte is dropped, pointers and `count` are unchanged, and `overrun` is set to 1.
- Pop: `in_ack` while `count` != 0 increments `rd_ptr`. `in_ack` while empty is ignored; pointers are unchanged and no error is flagged. The core must not assert it then, and the bench treats it as a protocol violation.
- Simultaneous push and pop: both take effect and `count` is unchanged. This holds when empty as well: the pop is ignored, the push is accepted, and `count` becomes 1.
- `count` next value: +1 on accepted push only, −1 on valid pop only, otherwise unchanged.
- `Rx_ready` = (`count` != 0).
- `in_data` = `mem[rd_ptr]` when `count` != 0, else 0. It is a combinational read of the registered array (first-word fall-through).
- `overrun`: on a dropped push it is set. Otherwise `overrun_clr` clears it. If a drop and `overrun_clr` occur in the same cycle, set wins and the result is 1.
- Storage contents are not reset. Only the pointers, `count` and `overrun` are reset.

## Timing

- Reset (`rstn` low, asynchronous): immediately `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overrun`=0, so `Rx_ready`=0 and `in_data`=0. Reset asserted mid-stream discards all queued bytes. The first edge after deassertion is a normal cycle.
- Push latency: `rx_valid` at edge k makes `Rx_ready`=1 and `in_data` show the byte after edge k, i.e. in the cycle following the strobe.
- Pop latency: `in_ack` at edge k makes the next byte (or 0 and `Rx_ready`=0 if now empty) appear after edge k. A back-to-back pop on consecutive cycles is supported.
- No combinational path from `rx_valid`/`rx_data` to any output. `in_ack` affects outputs only through registers.
- Full boundary: at `count`=DEPTH, `Rx_ready`=1 and pointers are equal. Wrap-around of both pointers is seamless.

## Test plan

- Reset then single byte: `rx_valid` with 0x41 at cycle 5 -> `Rx_ready`=1, `in_data`=0x41, `count`=1 from cycle 6. `in_ack` at cycle 8 -> `Rx_ready`=0, `in_data`=0, `count`=0 from cycle 9.
- Order and wrap: push 0x00..0x27 (40 bytes), interleaved with pops at a 1:1 rate after 3 initial pushes -> popped sequence exactly 0x00..0x27, `count` never exceeds 3, `overrun`=0.
- Fill and overrun: push 0x10..0x20 (17 bytes) with no pops -> `count`=16, `overrun`=1, and pops return 0x10..0x1F; 0x20 is lost.
- Full with simultaneous push/pop: at `count`=16 assert `rx_valid` (0x99) and `in_ack` together -> `count` stays 16, `overrun` stays 0, and 0x99 is the last byte popped.
- Overrun clear race: a dropped push coincides with `overrun_clr` -> `overrun`=1. Then `overrun_clr` alone -> `overrun`=0 next cycle.
- Reset mid-operation: with `count`=7, pulse `rstn` low between edges -> `Rx_ready`, `count` and `in_data` are 0 immediately. A subsequent push of 0x55 is the only byte read out.

Source files
------------

// File: rtl/rx_buffer_vliw.sv
// Receive byte buffer between the UART receiver and the VLIW core's `in` path.
// Circular FIFO with first-word fall-through head, occupancy count and sticky overrun.
module rx_buffer_vliw #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_valid,
    input  logic                  in_ack,
    input  logic                  overrun_clr,
    output logic                  Rx_ready,
    output logic [WIDTH-1:0]      in_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun
);

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure (a byte
    // arriving while full is dropped); in_ack pops the head only while Rx_ready=1.
    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overrun_q;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count_q == DEPTH_CNT);
    assign pop  = in_ack && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push = rx_valid && (!full || pop);
    assign drop = rx_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign Rx_ready = (count_q != '0);
    assign in_data  = Rx_ready ? mem[rd_ptr] : '0;
    assign count    = count_q;
    assign overrun  = overrun_q;

endmodule
